// File: rtl/dbus_responder_pkg.sv
// Shared data-bus types for the responder and the fetch/memory dbus mux.
// Also holds the responder state enum and a byte-strobe helper.
package dbus_responder_pkg;

  typedef enum logic [2:0] {
    MSIZE1 = 3'd0,
    MSIZE2 = 3'd1,
    MSIZE4 = 3'd2,
    MSIZE8 = 3'd3
  } msize_t;

  typedef struct packed {
    logic        valid;
    logic [63:0] addr;
    msize_t      size;
    logic [7:0]  strobe;
    logic [63:0] data;
  } dbus_req_t;

  typedef struct packed {
    logic        addr_ok;
    logic        data_ok;
    logic [63:0] data;
  } dbus_resp_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } resp_state_t;

  // Expands one strobe bit per byte lane into a 64-bit bit mask.
  function automatic logic [63:0] strobe_mask(input logic [7:0] strobe);
    logic [63:0] m;
    for (int b = 0; b < 8; b++) m[b*8 +: 8] = {8{strobe[b]}};
    return m;
  endfunction

endpackage

// File: rtl/dbus_responder_strobe_ram.sv
// DEPTH_WORDS x 64 storage: combinational read, synchronous byte-enabled write.
// Contents are deliberately not reset so data survives a responder reset.
module strobe_ram
  import dbus_responder_pkg::*;
#(
  parameter int DEPTH_WORDS = 4096,
  parameter int AW          = 12
) (
  input  logic          clk,
  input  logic [AW-1:0] raddr_i,
  output logic [63:0]   rdata_o,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [7:0]    be_i,
  input  logic [63:0]   wdata_i
);

  logic [63:0] mem_q [DEPTH_WORDS];
  logic [63:0] mask;

  assign rdata_o = mem_q[raddr_i];
  assign mask    = strobe_mask(be_i);

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= (mem_q[waddr_i] & ~mask) | (wdata_i & mask);
  end

endmodule

// File: rtl/dbus_responder.sv
// Data-bus responder: accepts one request, waits LATENCY cycles, then returns
// read data or commits a strobed write to the local strobe_ram.
module dbus_responder
  import dbus_responder_pkg::*;
#(
  parameter logic [63:0] BASE_ADDR   = 64'h0000_0000_8000_0000,
  parameter int          DEPTH_WORDS = 4096,
  parameter int          LATENCY     = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  dbus_req_t  dreq,
  output dbus_resp_t dresp
);

  localparam int          AW       = $clog2(DEPTH_WORDS);
  localparam logic [63:0] DEPTH64  = 64'(DEPTH_WORDS);
  localparam logic [3:0]  CNT_LOAD = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

  resp_state_t state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [63:0] addr_q, addr_d;
  logic [63:0] data_q, data_d;
  logic [7:0]  strobe_q, strobe_d;
  msize_t      size_q, size_d;

  logic [63:0]   word_off;
  logic          in_range;
  logic [AW-1:0] idx;
  logic [63:0]   rdata;
  logic          is_write;
  logic          accept;
  logic          respond;
  logic          we;

  // Addresses below BASE_ADDR wrap to a huge offset, so the explicit >= check is belt and braces.
  assign word_off = (addr_q - BASE_ADDR) >> 3;
  assign in_range = (addr_q >= BASE_ADDR) && (word_off < DEPTH64);
  assign idx      = word_off[AW-1:0];
  assign is_write = |strobe_q;

  // The core keeping valid high is what lets WAIT/RESP proceed; dropping it aborts.
  assign accept  = !reset && (state_q == IDLE) && dreq.valid;
  assign respond = !reset && (state_q == RESP) && dreq.valid;
  assign we      = respond && is_write && in_range;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    data_d   = data_q;
    strobe_d = strobe_q;
    size_d   = size_q;
    unique case (state_q)
      IDLE: begin
        if (dreq.valid) begin
          addr_d   = dreq.addr;
          data_d   = dreq.data;
          strobe_d = dreq.strobe;
          size_d   = dreq.size;
          if (LATENCY > 0) begin
            state_d = WAIT;
            cnt_d   = CNT_LOAD;
          end else begin
            state_d = RESP;
          end
        end
      end
      WAIT: begin
        if (!dreq.valid)       state_d = IDLE;
        else if (cnt_q == '0)  state_d = RESP;
        else                   cnt_d   = cnt_q - 4'd1;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      addr_q   <= '0;
      data_q   <= '0;
      strobe_q <= '0;
      size_q   <= MSIZE1;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      strobe_q <= strobe_d;
      size_q   <= size_d;
    end
  end

  strobe_ram #(
    .DEPTH_WORDS(DEPTH_WORDS),
    .AW         (AW)
  ) u_ram (
    .clk    (clk),
    .raddr_i(idx),
    .rdata_o(rdata),
    .we_i   (we),
    .waddr_i(idx),
    .be_i   (strobe_q),
    .wdata_i(data_q)
  );

  always_comb begin
    dresp         = '0;
    dresp.addr_ok = accept;
    dresp.data_ok = respond;
    if (respond && !is_write && in_range) dresp.data = rdata;
  end

endmodule

// File: tb/tb_dbus_responder.sv
// Randomized bench for dbus_responder against a word-array memory model,
// plus directed cases for latency, aborts, reset and out-of-range accesses.
module tb_dbus_responder;
  import dbus_responder_pkg::*;

  localparam logic [63:0] BASE    = 64'h0000_0000_8000_0000;
  localparam int          DEPTH   = 4096;
  localparam int          LAT_A   = 2;
  localparam int          DEPTH_B = 16;
  localparam int          WIN     = 16;

  logic       clk = 1'b0;
  logic       reset;
  dbus_req_t  dreq_a, dreq_b;
  dbus_resp_t dresp_a, dresp_b;

  int n_cmp = 0;
  int n_err = 0;
  logic [63:0] mdl [int];

  always #5 clk = ~clk;

  dbus_responder #(.BASE_ADDR(BASE), .DEPTH_WORDS(DEPTH), .LATENCY(LAT_A)) u_dut_a (
    .clk(clk), .reset(reset), .dreq(dreq_a), .dresp(dresp_a));

  dbus_responder #(.BASE_ADDR(BASE), .DEPTH_WORDS(DEPTH_B), .LATENCY(0)) u_dut_b (
    .clk(clk), .reset(reset), .dreq(dreq_b), .dresp(dresp_b));

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic bit in_win(input logic [63:0] a);
    return (a >= BASE) && (a < BASE + 64'(8 * DEPTH));
  endfunction

  function automatic int widx(input logic [63:0] a);
    return int'((a - BASE) / 64'd8);
  endfunction

  function automatic logic [63:0] mdl_read(input logic [63:0] a);
    if (!in_win(a) || !mdl.exists(widx(a))) return 64'd0;
    return mdl[widx(a)];
  endfunction

  task automatic mdl_write(input logic [63:0] a, input logic [7:0] s, input logic [63:0] d);
    logic [63:0] w;
    if (!in_win(a)) return;
    w = mdl_read(a);
    for (int b = 0; b < 8; b++) if (s[b]) w[b*8 +: 8] = d[b*8 +: 8];
    mdl[widx(a)] = w;
  endtask

  task automatic drive_a(input logic v, input logic [63:0] a, input logic [7:0] s, input logic [63:0] d);
    dreq_a.valid  = v;
    dreq_a.addr   = a;
    dreq_a.size   = msize_t'($urandom_range(0, 3));
    dreq_a.strobe = s;
    dreq_a.data   = d;
  endtask

  // One transaction on DUT A; request fields are scrambled after acceptance.
  task automatic txn_a(input string tag, input logic [63:0] a, input logic [7:0] s, input logic [63:0] d);
    logic [63:0] exp;
    bit done;
    done = 0;
    exp  = (s == 8'd0) ? mdl_read(a) : 64'd0;
    drive_a(1'b1, a, s, d);
    for (int cyc = 0; cyc < 12 && !done; cyc++) begin
      @(negedge clk);
      check({tag, ".addr_ok"}, 64'(dresp_a.addr_ok), 64'(cyc == 0));
      if (dresp_a.data_ok) begin
        check({tag, ".lat"}, 64'(cyc), 64'(LAT_A + 1));
        check({tag, ".data"}, dresp_a.data, exp);
        done = 1;
      end else begin
        check({tag, ".quiet_data"}, dresp_a.data, 64'd0);
        @(posedge clk); #1;
        drive_a(1'b1, {$urandom, $urandom}, 8'($urandom), {$urandom, $urandom});
      end
    end
    check({tag, ".done"}, 64'(done), 64'd1);
    if (s != 8'd0) mdl_write(a, s, d);
    @(posedge clk); #1;
    dreq_a.valid = 1'b0;
  endtask

  // LATENCY=0 DUT with valid held across two transactions.
  task automatic b2b_b(input string tag, input logic [63:0] a0, input logic [63:0] a1, input logic [7:0] s,
                       input logic [63:0] d0, input logic [63:0] d1, input logic [63:0] e0, input logic [63:0] e1);
    dreq_b.valid  = 1'b1;
    dreq_b.addr   = a0;
    dreq_b.size   = MSIZE8;
    dreq_b.strobe = s;
    dreq_b.data   = d0;
    for (int cyc = 0; cyc < 4; cyc++) begin
      @(negedge clk);
      check({tag, ".addr_ok"}, 64'(dresp_b.addr_ok), 64'(cyc % 2 == 0));
      check({tag, ".data_ok"}, 64'(dresp_b.data_ok), 64'(cyc % 2 == 1));
      check({tag, ".data"}, dresp_b.data, (cyc == 1) ? e0 : (cyc == 3) ? e1 : 64'd0);
      @(posedge clk); #1;
      if (cyc == 1) begin
        dreq_b.addr = a1;
        dreq_b.data = d1;
      end
    end
    dreq_b.valid = 1'b0;
  endtask

  task automatic sweep_win(input string tag);
    for (int w = 0; w < WIN; w++) txn_a(tag, BASE + 64'(8 * w), 8'd0, 64'd0);
  endtask

  initial begin
    logic [63:0] addr, old, da, db;
    logic [7:0]  s;

    reset = 1'b1;
    drive_a(1'b1, BASE, 8'hFF, {$urandom, $urandom});
    dreq_b = dreq_a;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("rst.a_ok", {62'd0, dresp_a.addr_ok, dresp_a.data_ok}, 64'd0);
      check("rst.a_data", dresp_a.data, 64'd0);
      check("rst.b_ok", {62'd0, dresp_b.addr_ok, dresp_b.data_ok}, 64'd0);
      @(posedge clk); #1;
    end
    reset = 1'b0;
    dreq_a.valid = 1'b0;
    dreq_b.valid = 1'b0;
    @(posedge clk); #1;

    txn_a("full_wr", 64'h8000_0008, 8'hFF, 64'h1122_3344_5566_7788);
    txn_a("full_rd", 64'h8000_0008, 8'h00, 64'd0);
    txn_a("half_wr", 64'h8000_0008, 8'h0F, 64'hAAAA_AAAA_BBBB_BBBB);
    txn_a("half_rd", 64'h8000_0008, 8'h00, 64'd0);
    check("half_mdl", mdl_read(64'h8000_0008), 64'h1122_3344_BBBB_BBBB);

    for (int w = 0; w < WIN; w++) txn_a("init", BASE + 64'(8 * w), 8'hFF, {$urandom, $urandom});

    for (int i = 0; i < 200; i++) begin
      if ($urandom_range(0, 9) == 0) begin
        case ($urandom_range(0, 2))
          0:       addr = BASE - 64'(8 * (1 + $urandom_range(0, 15)));
          1:       addr = BASE + 64'(8 * DEPTH) + 64'(8 * $urandom_range(0, 15));
          default: addr = {$urandom, $urandom} | 64'h0001_0000_0000_0000;
        endcase
      end else begin
        addr = BASE + 64'(8 * $urandom_range(0, WIN - 1)) + 64'($urandom_range(0, 7));
      end
      s = ($urandom_range(0, 2) == 0) ? 8'd0 : 8'($urandom);
      txn_a("rand", addr, s, {$urandom, $urandom});
    end

    txn_a("oor_rd", 64'h0000_0000_7FFF_FFF8, 8'h00, 64'd0);
    txn_a("oor_wr", BASE + 64'(8 * DEPTH), 8'hFF, 64'hDEAD_BEEF_CAFE_F00D);
    sweep_win("oor_sweep");

    addr = BASE + 64'(8 * 5);
    old  = mdl_read(addr);
    drive_a(1'b1, addr, 8'hFF, ~old);
    @(negedge clk); check("abw.addr_ok", 64'(dresp_a.addr_ok), 64'd1);
    @(posedge clk); #1; dreq_a.valid = 1'b0;
    @(negedge clk); check("abw.data_ok", 64'(dresp_a.data_ok), 64'd0);
    @(posedge clk); #1;
    txn_a("abw.rd", addr, 8'h00, 64'd0);

    drive_a(1'b1, addr, 8'hFF, ~old);
    for (int c = 0; c < LAT_A + 1; c++) begin
      @(negedge clk);
      check("abr.addr_ok", 64'(dresp_a.addr_ok), 64'(c == 0));
      check("abr.data_ok", 64'(dresp_a.data_ok), 64'd0);
      @(posedge clk); #1;
    end
    dreq_a.valid = 1'b0;
    @(negedge clk); check("abr.resp_data_ok", 64'(dresp_a.data_ok), 64'd0);
    @(posedge clk); #1;
    txn_a("abr.rd", addr, 8'h00, 64'd0);

    addr = BASE + 64'(8 * 7);
    old  = mdl_read(addr);
    drive_a(1'b1, addr, 8'hFF, ~old);
    @(negedge clk); check("rsw.addr_ok", 64'(dresp_a.addr_ok), 64'd1);
    @(posedge clk); #1; reset = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("rsw.ok", {62'd0, dresp_a.addr_ok, dresp_a.data_ok}, 64'd0);
      check("rsw.data", dresp_a.data, 64'd0);
      @(posedge clk); #1;
    end
    reset = 1'b0;
    dreq_a.valid = 1'b0;
    @(posedge clk); #1;
    txn_a("rsw.rd", addr, 8'h00, 64'd0);

    da = {$urandom, $urandom};
    db = {$urandom, $urandom};
    b2b_b("b.wr", BASE + 64'd16, BASE + 64'd24, 8'hFF, da, db, 64'd0, 64'd0);
    b2b_b("b.rd", BASE + 64'd16, BASE + 64'd24, 8'h00, 64'd0, 64'd0, da, db);

    sweep_win("final");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/dbus_responder.md
DBUS_RESPONDER -- requirements
Module: dbus_responder

Interface
REQ-001 The block SHALL have parameter BASE_ADDR, default 64'h0000_0000_8000_0000, meaning the byte address of word 0.
REQ-002 The block SHALL have parameter DEPTH_WORDS, default 4096, meaning the number of 64-bit storage words (power of two).
REQ-003 The block SHALL have parameter LATENCY, default 2, meaning the wait cycles between acceptance and response (legal range 0..15).
REQ-004 clk  input  1  single clock; all state changes on its rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 dreq  input  dbus_req_t  request from the core: valid, addr, size, strobe, data.
REQ-007 dresp  output  dbus_resp_t  response to the core: addr_ok, data_ok, data.

Function
REQ-008 The block SHALL implement states IDLE, WAIT and RESP, held in a state register.
REQ-009 In IDLE with dreq.valid=1, the block SHALL latch addr, size, strobe and data and assert addr_ok for exactly that cycle.
REQ-010 From IDLE on acceptance, the next state SHALL be WAIT when LATENCY>0, otherwise RESP.
REQ-011 On entry to WAIT, a 4-bit counter SHALL load LATENCY-1 and decrement each cycle; the block SHALL move to RESP in the cycle after the counter reads 0.
REQ-012 In RESP, the block SHALL assert data_ok for exactly one cycle and then return to IDLE.
REQ-013 Request-to-data_ok latency SHALL be LATENCY+1 cycles, counting the acceptance cycle as cycle 0.
REQ-014 A request with strobe==0 SHALL be a read; dresp.data in RESP SHALL equal the full 64-bit word at the latched address, and byte lanes SHALL NOT be shifted.
REQ-015 A request with strobe!=0 SHALL be a write; on the RESP cycle only the bytes whose strobe bit is 1 SHALL be updated, and dresp.data SHALL be 0.
REQ-016 Word index SHALL be (addr-BASE_ADDR)>>3; addr[2:0] and size SHALL be ignored for indexing.
REQ-017 An address outside [BASE_ADDR, BASE_ADDR+8*DEPTH_WORDS) SHALL still complete normally: reads return 0, writes are dropped, and no hang occurs.
REQ-018 Changes to dreq fields after acceptance SHALL be ignored; the latched copies are used.
REQ-019 If dreq.valid drops during WAIT or RESP, the transaction SHALL be aborted: the block returns to IDLE next cycle, performs no write and asserts no data_ok.
REQ-020 A request whose valid stays high in the cycle after data_ok SHALL be accepted as a new transaction; back-to-back throughput is one transaction per LATENCY+2 cycles.
REQ-021 Outside the acceptance and RESP cycles, addr_ok, data_ok and data SHALL be 0.

Reset
REQ-022 While reset=1, the next state SHALL be IDLE, the counter 0 and the latches 0.
REQ-023 During reset, dresp SHALL be all zero.
REQ-024 Reset during WAIT or RESP SHALL abort the transaction with no write.
REQ-025 Reset SHALL NOT clear storage contents.

Structure
REQ-026 dbus_req_t, dbus_resp_t and msize_t SHALL be taken from the common package; a state enum resp_state_t {IDLE, WAIT, RESP} SHALL be added to the common package.
REQ-027 Storage SHALL be the sub-module strobe_ram: DEPTH_WORDS x 64 bits, with a combinational read port and one synchronous write port with 8-bit byte enables.
REQ-028 The responder SHALL be usable behind the existing fetch/memory dbus mux without modification to that mux.

Verification
REQ-029 Scenario: LATENCY=2, write addr 0x8000_0008, strobe 0xFF, data 0x1122334455667788 -> addr_ok at cycle 0, data_ok at cycle 3; a read of the same address returns 0x1122334455667788.
REQ-030 Scenario: write strobe 0x0F, data 0xAAAAAAAA_BBBBBBBB over a word holding 0x11223344_55667788 -> a read returns 0x11223344_BBBBBBBB.
REQ-031 Scenario: read addr 0x7FFF_FFF8 and write addr BASE_ADDR+8*DEPTH_WORDS -> both complete with data_ok, the read returns 0, and no storage word changes.
REQ-032 Scenario: write accepted, then valid dropped at cycle 1 -> no data_ok, the word is unchanged and the state is IDLE at cycle 2.
REQ-033 Scenario: reset asserted during WAIT of a write -> dresp is 0 and the write is not performed; a read after reset returns the previous contents.
REQ-034 Scenario: LATENCY=0, valid held continuously with two reads -> addr_ok at cycles 0 and 2, data_ok at cycles 1 and 3.
